// File: rtl/data_mem_ctrl.sv
// Data memory with valid/ready request port, byte-lane stores, RD_LAT-deep load
// pipeline, out-of-range error flag and a post-reset zero-fill sequence.
module data_mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_ready;
  logic              w_done;
  logic              w_accept;
  logic              w_in_range;
  logic              w_ld;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [NB-1:0]     w_mem_be;
  logic [DATA_W-1:0] w_rd_data;

  logic              r_pv [RD_LAT];
  logic [DATA_W-1:0] r_pd [RD_LAT];
  logic              r_pe [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_CLEAR: if (r_ptr == LAST_IDX) w_state_nxt = S_RUN;
      S_RUN: begin
        w_ready = 1'b1;
        w_done  = 1'b1;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  assign req_ready = w_ready;
  assign init_done = w_done;

  always_ff @(posedge clk) begin
    if (rst)                       r_ptr <= '0;
    else if (r_state == S_CLEAR)   r_ptr <= r_ptr + 1'b1;
  end

  // Full-width compare so out-of-range addresses never alias onto real words.
  assign w_in_range = ({1'b0, req_addr} < DEPTH_EXT);
  assign w_accept   = req_valid && w_ready;
  assign w_ld       = w_accept && !req_we;

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = req_addr[IDX_W-1:0];
    w_mem_wdata = req_wdata;
    w_mem_be    = req_be;
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_ptr;
        w_mem_wdata = '0;
        w_mem_be    = '1;
      end else begin
        w_mem_we = w_accept && req_we && w_in_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (w_mem_be[i]) r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (w_in_range) w_rd_data = r_mem[req_addr[IDX_W-1:0]];
  end

  // Stage data only advances with its valid bit, so the last stage holds the
  // previous response while rsp_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
        r_pe[i] <= 1'b0;
      end
    end else begin
      r_pv[0] <= w_ld;
      if (w_ld) begin
        r_pd[0] <= w_rd_data;
        r_pe[0] <= !w_in_range;
      end
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) begin
          r_pd[i] <= r_pd[i-1];
          r_pe[i] <= r_pe[i-1];
        end
      end
    end
  end

  assign rsp_valid = r_pv[RD_LAT-1];
  assign rsp_rdata = r_pd[RD_LAT-1];
  assign rsp_err   = r_pe[RD_LAT-1];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: identical stimulus drives an RD_LAT=1 and an RD_LAT=3
// instance; each has its own expected-response queue and monitor.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;

  logic        rdy1, v1, e1, done1;
  logic [31:0] d1;
  logic        rdy3, v3, e3, done3;
  logic [31:0] d3;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(12), .DEPTH(32), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(v1), .rsp_rdata(d1), .rsp_err(e1), .init_done(done1));

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(12), .DEPTH(32), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(v3), .rsp_rdata(d3), .rsp_err(e3), .init_done(done3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (q1.size() != 0 && q1[0].due < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp1_missing: no response by cycle %0d, expected %h", q1[0].due, q1[0].d);
      void'(q1.pop_front());
    end
    if (v1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp1_unexpected: got rsp_valid with %h, expected none", d1);
      end else begin
        x = q1.pop_front();
        chk("rsp1_data", d1, x.d);
        chk("rsp1_err", {31'b0, e1}, {31'b0, x.e});
        chk("rsp1_cycle", cyc, x.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (q3.size() != 0 && q3[0].due < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp3_missing: no response by cycle %0d, expected %h", q3[0].due, q3[0].d);
      void'(q3.pop_front());
    end
    if (v3 === 1'b1) begin
      if (q3.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp3_unexpected: got rsp_valid with %h, expected none", d3);
      end else begin
        x = q3.pop_front();
        chk("rsp3_data", d3, x.d);
        chk("rsp3_err", {31'b0, e3}, {31'b0, x.e});
        chk("rsp3_cycle", cyc, x.due);
      end
    end
  end

  // Drives one request for one cycle, starting at a negedge.
  task automatic req(input logic we, input logic [11:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input logic [31:0] xd, input logic xe,
                     input logic push3);
    exp_t x;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    if (!we) begin
      x.d = xd; x.e = xe;
      x.due = cyc + 1; q1.push_back(x);
      if (push3) begin
        x.due = cyc + 3; q3.push_back(x);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic st(input logic [11:0] a, input logic [31:0] wd, input logic [3:0] be);
    req(1'b1, a, wd, be, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic ld(input logic [11:0] a, input logic [31:0] xd, input logic xe);
    req(1'b0, a, 32'h0, 4'h0, xd, xe, 1'b1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready1"}, {31'b0, rdy1}, 32'h0);
    chk({tag, "_ready3"}, {31'b0, rdy3}, 32'h0);
    chk({tag, "_valid1"}, {31'b0, v1}, 32'h0);
    chk({tag, "_valid3"}, {31'b0, v3}, 32'h0);
    chk({tag, "_rdata1"}, d1, 32'h0);
    chk({tag, "_rdata3"}, d3, 32'h0);
    chk({tag, "_err3"}, {31'b0, e3}, 32'h0);
    chk({tag, "_done1"}, {31'b0, done1}, 32'h0);
    chk({tag, "_done3"}, {31'b0, done3}, 32'h0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk_reset_outs("rst");
    rst = 1'b0;

    repeat (31) @(negedge clk);
    chk("clr_done_early1", {31'b0, done1}, 32'h0);
    chk("clr_ready_early3", {31'b0, rdy3}, 32'h0);
    @(negedge clk);
    chk("clr_done1", {31'b0, done1}, 32'h1);
    chk("clr_ready1", {31'b0, rdy1}, 32'h1);
    chk("clr_done3", {31'b0, done3}, 32'h1);

    ld(12'd0, 32'h0, 1'b0);
    ld(12'd17, 32'h0, 1'b0);
    ld(12'd31, 32'h0, 1'b0);

    st(12'd0, 32'h00000D1F, 4'hF);
    st(12'd1, 32'h00001000, 4'hF);
    ld(12'd0, 32'h00000D1F, 1'b0);
    ld(12'd1, 32'h00001000, 1'b0);

    st(12'd5, 32'hAABBCCDD, 4'hF);
    st(12'd5, 32'h11223344, 4'b0101);
    ld(12'd5, 32'hAA22CC44, 1'b0);
    st(12'd5, 32'hFFFFFFFF, 4'h0);
    ld(12'd5, 32'hAA22CC44, 1'b0);

    st(12'd32, 32'hDEADBEEF, 4'hF);
    ld(12'd32, 32'h0, 1'b1);
    ld(12'hFFF, 32'h0, 1'b1);
    ld(12'd0, 32'h00000D1F, 1'b0);
    ld(12'd31, 32'h0, 1'b0);
    ld(12'd1, 32'h00001000, 1'b0);
    repeat (5) @(negedge clk);
    chk("hold_rdata1", d1, 32'h00001000);
    chk("hold_rdata3", d3, 32'h00001000);

    st(12'd3, 32'h33333333, 4'hF);
    ld(12'd1, 32'h00001000, 1'b0);
    ld(12'd2, 32'h0, 1'b0);
    ld(12'd3, 32'h33333333, 1'b0);
    ld(12'd1, 32'h00001000, 1'b0);
    st(12'd2, 32'h22222222, 4'hF);
    ld(12'd2, 32'h22222222, 1'b0);
    ld(12'd3, 32'h33333333, 1'b0);
    repeat (5) @(negedge clk);

    // Mid-flight reset: the RD_LAT=1 instance answers before rst lands, the
    // RD_LAT=3 instance must drop both loads.
    req(1'b0, 12'd1, 32'h0, 4'h0, 32'h00001000, 1'b0, 1'b0);
    req(1'b0, 12'd3, 32'h0, 4'h0, 32'h33333333, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("midrst");
    rst = 1'b0;

    n = 0;
    while (done1 !== 1'b1 && n < 40) begin
      if (n < 20) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'd0;
        req_wdata = 32'hBADBAD00; req_be = 4'hF;
      end else begin
        req_valid = 1'b0;
      end
      if (n == 10) chk("clr_ready_low3", {31'b0, rdy3}, 32'h0);
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    chk("reclr_len", n, 32);
    chk("reclr_done3", {31'b0, done3}, 32'h1);

    for (int a = 0; a < 32; a++) ld(12'(a), 32'h0, 1'b0);

    repeat (6) @(negedge clk);
    chk("q1_drained", q1.size(), 32'h0);
    chk("q3_drained", q3.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got cycle %0d expected under 20000", cyc);
    $fatal(1, "timeout");
  end

endmodule
